stack_ctrl: RTL and testbench

- Sequencer and arbiter for the processor's hardware stack memory.
- Two requesters share a single synchronous-read stack RAM: A is the core CALL/RET/PUSH/POP path, B is the interrupt context-save unit.
- The block owns the stack pointer, arbitrates push and pop requests, drives the RAM port, and flags overflow and underflow.
- The stack grows downward: the first push writes address NDATAS-1.

---
 rtl/stack_ctrl.sv | 159 +++++++++++++++
 tb/tb_stack_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_ctrl
// Description : Hardware stack sequencer. Arbitrates push/pop requests from
//               two requesters (A = core, B = interrupt context save) onto a
//               single synchronous-read stack RAM. Owns the stack pointer and
//               reports overflow/underflow. Stack grows downward.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_ctrl #(
    parameter int NADDRW = 8,
    parameter int NDATAS = 256,
    parameter int NWORDW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_push,
    input  logic [NWORDW-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_push,
    input  logic [NWORDW-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [NWORDW-1:0] rdata,
    output logic              mem_we,
    output logic [NADDRW-1:0] mem_addr,
    output logic [NWORDW-1:0] mem_wdata,
    input  logic [NWORDW-1:0] mem_rdata,
    output logic [NADDRW:0]   depth,
    output logic              full,
    output logic              empty
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    localparam logic [NADDRW-1:0] C_SP_TOP    = NADDRW'(NDATAS - 1);
    localparam logic [NADDRW-1:0] C_SP_ONE    = NADDRW'(1);
    localparam logic [NADDRW:0]   C_DEPTH_MAX = (NADDRW + 1)'(NDATAS);
    localparam logic [NADDRW:0]   C_DEPTH_ONE = (NADDRW + 1)'(1);

    logic [2:0]        state_q, state_d;
    logic [NADDRW-1:0] sp_q, sp_d;
    logic [NADDRW:0]   depth_q, depth_d;
    logic [NWORDW-1:0] rdata_q, rdata_d;
    logic [NWORDW-1:0] wdata_q, wdata_d;
    logic              gnt_b_q, gnt_b_d;   // current / most recent grant is B
    logic              err_q, err_d;

    logic              w_gnt_b;
    logic              w_sel_push;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (depth_q == C_DEPTH_MAX);
    assign w_empty = (depth_q == '0);

    // Round-robin choice: B wins when alone, or when both ask and A went last.
    // gnt_b_q resets to 1 so that A wins the first contested arbitration.
    assign w_gnt_b    = b_req && (!a_req || !gnt_b_q);
    assign w_sel_push = w_gnt_b ? b_push : a_push;

    // Next-state, pointer and data-path logic.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        gnt_b_d = gnt_b_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (a_req || b_req) begin
                    gnt_b_d = w_gnt_b;
                    wdata_d = w_gnt_b ? b_wdata : a_wdata;
                    err_d   = w_sel_push ? w_full : w_empty;
                    if (w_sel_push ? w_full : w_empty) begin
                        state_d = S_ACK;
                    end else if (w_sel_push) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                sp_d    = sp_q - C_SP_ONE;
                depth_d = depth_q + C_DEPTH_ONE;
                state_d = S_ACK;
            end
            S_READ: begin
                sp_d    = sp_q + C_SP_ONE;
                depth_d = depth_q - C_DEPTH_ONE;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                rdata_d = mem_rdata;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sp_q    <= C_SP_TOP;
            depth_q <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            gnt_b_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            gnt_b_q <= gnt_b_d;
            err_q   <= err_d;
        end
    end

    // RAM port: pop reads the slot above sp, everything else presents sp.
    always_comb begin
        mem_addr = sp_q;
        if (state_q == S_READ) begin
            mem_addr = sp_q + C_SP_ONE;
        end
    end

    assign mem_we    = (state_q == S_WRITE);
    assign mem_wdata = wdata_q;

    assign a_ack = (state_q == S_ACK) && !gnt_b_q;
    assign b_ack = (state_q == S_ACK) &&  gnt_b_q;
    assign a_err = a_ack && err_q;
    assign b_err = b_ack && err_q;

    assign rdata = rdata_q;
    assign depth = depth_q;
    assign full  = w_full;
    assign empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_ctrl
// Description : Self-checking bench for stack_ctrl (NADDRW=3, NDATAS=8).
//               Table of single operations plus hand-written multi-cycle
//               sequences (simultaneous requests, round-robin, reset in RWAIT).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

    localparam int AW = 3;
    localparam int ND = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_push, a_ack, a_err;
    logic          b_req, b_push, b_ack, b_err;
    logic [DW-1:0] a_wdata, b_wdata, rdata, mem_wdata, mem_rdata;
    logic          mem_we, full, empty;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   depth;

    logic [DW-1:0] ram [0:ND-1];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit            use_b;
        bit            push;
        logic [DW-1:0] wd;
        bit            err;
        logic [DW-1:0] rd;     // rdata expected in the ack cycle
        int            depth;  // depth expected in the ack cycle
        int            addr;   // RAM address of the write / read
    } vec_t;

    vec_t vecs [17];

    stack_ctrl #(.NADDRW(AW), .NDATAS(ND), .NWORDW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_push(a_push), .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_push(b_push), .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .depth(depth), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        a_req = 0; b_req = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t mk(bit use_b, bit push, logic [DW-1:0] wd, bit err,
                                logic [DW-1:0] rd, int dp, int addr);
        vec_t v;
        v.use_b = use_b; v.push = push; v.wd = wd; v.err = err;
        v.rd = rd; v.depth = dp; v.addr = addr;
        return v;
    endfunction

    // Issue one operation, wait (bounded) for its ack and check everything.
    task automatic run_op(input string tag, input vec_t v);
        int            n;
        bit            got, we_seen, other_ack;
        logic [AW-1:0] we_addr, rd_addr;
        logic [DW-1:0] we_data;
        int            exp_lat;
        @(negedge clk);
        if (v.use_b) begin b_req = 1; b_push = v.push; b_wdata = v.wd; end
        else         begin a_req = 1; a_push = v.push; a_wdata = v.wd; end
        n = 0; got = 0; we_seen = 0; other_ack = 0;
        we_addr = '0; rd_addr = '0; we_data = '0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_we) begin we_seen = 1; we_addr = mem_addr; we_data = mem_wdata; end
            if (n == 1) rd_addr = mem_addr;
            if (v.use_b ? a_ack : b_ack) other_ack = 1;
            got = v.use_b ? b_ack : a_ack;
        end
        a_req = 0; b_req = 0;
        exp_lat = v.err ? 1 : (v.push ? 2 : 3);
        check({tag, " ack"}, got, 1);
        check({tag, " latency"}, n, exp_lat);
        check({tag, " err"}, v.use_b ? b_err : a_err, v.err);
        check({tag, " other_ack"}, other_ack, 0);
        check({tag, " mem_we"}, we_seen, v.push && !v.err);
        if (v.push && !v.err) begin
            check({tag, " wr_addr"}, we_addr, v.addr);
            check({tag, " wr_data"}, we_data, v.wd);
        end
        if (!v.push && !v.err) check({tag, " rd_addr"}, rd_addr, v.addr);
        check({tag, " rdata"}, rdata, v.rd);
        check({tag, " depth"}, depth, v.depth);
        check({tag, " full"}, full, v.depth == ND);
        check({tag, " empty"}, empty, v.depth == 0);
    endtask

    initial begin
        int          n;
        bit          dbl, seen_ack;
        int          order [$];
        logic [15:0] exp_wd;

        for (int i = 0; i < ND; i++) ram[i] = '0;
        a_req = 0; a_push = 0; a_wdata = '0;
        b_req = 0; b_push = 0; b_wdata = '0;

        // Operation table: idx, requester, op, data, err, rdata, depth, addr
        vecs[0] = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 0);   // pop on empty
        vecs[1] = mk(0, 1, 16'h1234, 0, 16'h0000, 1, 7);
        vecs[2] = mk(0, 0, 16'h0000, 0, 16'h1234, 0, 7);
        vecs[3] = mk(0, 1, 16'h0011, 0, 16'h1234, 1, 7);
        vecs[4] = mk(0, 1, 16'h0022, 0, 16'h1234, 2, 6);
        vecs[5] = mk(0, 0, 16'h0000, 0, 16'h0022, 1, 6);
        vecs[6] = mk(0, 0, 16'h0000, 0, 16'h0011, 0, 7);
        for (int i = 0; i < 8; i++) begin
            exp_wd = 16'hB000 + 16'(i);
            vecs[7+i] = mk(1, 1, exp_wd, 0, 16'h0011, i + 1, 7 - i);
        end
        vecs[15] = mk(0, 1, 16'hDEAD, 1, 16'h0011, 8, 0);  // push on full
        vecs[16] = mk(1, 0, 16'h0000, 0, 16'hB007, 7, 0);

        do_reset();
        @(negedge clk);
        check("rst a_ack", a_ack, 0);
        check("rst b_ack", b_ack, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 7);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst rdata", rdata, 0);
        check("rst depth", depth, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);

        for (int i = 0; i < 17; i++) run_op($sformatf("v%0d", i), vecs[i]);

        // Simultaneous pushes after reset: A first, then B
        do_reset();
        @(negedge clk);
        a_req = 1; a_push = 1; a_wdata = 16'hAAAA;
        b_req = 1; b_push = 1; b_wdata = 16'hBBBB;
        n = 0;
        while (!(a_ack || b_ack) && n < 10) begin @(negedge clk); n++; end
        check("sim first a_ack", a_ack, 1);
        check("sim first b_ack", b_ack, 0);
        a_req = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_ack && n < 10);
        check("sim second b_ack", b_ack, 1);
        b_req = 0;
        @(negedge clk);
        check("sim ram7", ram[7], 16'hAAAA);
        check("sim ram6", ram[6], 16'hBBBB);
        check("sim depth", depth, 2);

        // Both held high for four operations: grants alternate A,B,A,B
        do_reset();
        @(negedge clk);
        a_req = 1; a_push = 1; a_wdata = 16'h0A0A;
        b_req = 1; b_push = 1; b_wdata = 16'h0B0B;
        n = 0; dbl = 0;
        while (order.size() < 4 && n < 40) begin
            @(negedge clk); n++;
            if (a_ack && b_ack) dbl = 1;
            if (a_ack) order.push_back(0);
            else if (b_ack) order.push_back(1);
            if (order.size() == 4) begin a_req = 0; b_req = 0; end
        end
        a_req = 0; b_req = 0;
        check("rr ack count", order.size(), 4);
        check("rr double ack", dbl, 0);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) check($sformatf("rr grant%0d", i), order[i], i % 2);
        @(negedge clk);
        check("rr depth", depth, 4);

        // Reset asserted during RWAIT aborts the pop without an ack
        do_reset();
        run_op("rw push", mk(0, 1, 16'h5555, 0, 16'h0000, 1, 7));
        @(negedge clk);
        a_req = 1; a_push = 0;
        @(negedge clk);              // READ
        @(negedge clk);              // RWAIT
        rst = 1'b0;
        #1;
        check("rw a_ack", a_ack, 0);
        check("rw depth", depth, 0);
        check("rw mem_addr", mem_addr, 7);
        check("rw rdata", rdata, 0);
        a_req = 0;
        seen_ack = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin @(negedge clk); if (a_ack || b_ack) seen_ack = 1; end
        check("rw no ack", seen_ack, 0);
        run_op("rw pop empty", mk(0, 0, 16'h0000, 1, 16'h0000, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
